// File: rtl/multibyte_add_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multibyte_add_sequencer                                       |
// | Purpose  : Feeds two NBYTES-wide operands to an external 8-bit ripple    |
// |            adder one byte per cycle, LSB first. Each byte's carry-out    |
// |            becomes the next byte's carry-in. The assembled sum, final    |
// |            carry and signed overflow are returned over valid/ready.      |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            In_Valid/In_Ready, Op_A, Op_B, Cin_In   - operand handshake   |
// |            Adder_A/B/Cin0/Enable (enable active-low) - to the adder      |
// |            Adder_Sum, Adder_Cout8                  - from the adder      |
// |            Out_Valid/Out_Ready, Result, Cout_Out, Overflow - result      |
// | Options  : SUBTRACT_EN adds the Op_Sub input; when it is set the         |
// |            sequencer computes A - B (B inverted, carry-in forced to 1).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic [8*NBYTES-1:0] Op_A,
  input  logic [8*NBYTES-1:0] Op_B,
  input  logic                Cin_In,
`ifdef SUBTRACT_EN
  input  logic                Op_Sub,
`endif
  output logic [7:0]          Adder_A,
  output logic [7:0]          Adder_B,
  output logic                Adder_Cin0,
  output logic                Adder_Enable,
  input  logic [7:0]          Adder_Sum,
  input  logic                Adder_Cout8,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [8*NBYTES-1:0] Result,
  output logic                Cout_Out,
  output logic                Overflow
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [W-1:0]       r_op_a;
  logic [W-1:0]       r_op_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_result;
  logic               r_cout;
  logic               r_ovf;

  logic               w_sub;
  logic               w_accept;
  logic               w_last;
  logic [IDX_W+2:0]   w_bit_base;
  logic [7:0]         w_byte_a;
  logic [7:0]         w_byte_b;
  logic               w_a_msb;
  logic               w_b_msb;

`ifdef SUBTRACT_EN
  logic               r_sub;
  assign w_sub = r_sub;
`else
  assign w_sub = 1'b0;
`endif

  // Byte index scaled to a bit offset; width is exactly what addresses W bits.
  assign w_bit_base = {r_idx, 3'b000};
  assign w_byte_a   = r_op_a[w_bit_base +: 8];
  // Subtraction is A + ~B + 1: invert every B byte, carry seeded with 1.
  assign w_byte_b   = r_op_b[w_bit_base +: 8] ^ {8{w_sub}};
  assign w_last     = (r_idx == c_last_idx);
  assign w_accept   = (r_state == S_IDLE) && In_Valid;

  // Overflow is judged on the operand actually fed to the adder, so the
  // B sign bit is inverted for subtraction.
  assign w_a_msb    = r_op_a[W-1];
  assign w_b_msb    = r_op_b[W-1] ^ w_sub;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and handshake/adder outputs
  always_comb begin
    w_next_state = r_state;
    In_Ready     = 1'b0;
    Out_Valid    = 1'b0;
    Adder_Enable = 1'b1;
    Adder_A      = 8'h00;
    Adder_B      = 8'h00;
    Adder_Cin0   = 1'b0;
    case (r_state)
      S_IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          w_next_state = S_ADD;
        end
      end
      S_ADD: begin
        Adder_Enable = 1'b0;
        Adder_A      = w_byte_a;
        Adder_B      = w_byte_b;
        Adder_Cin0   = r_carry;
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand capture and byte-serial accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef SUBTRACT_EN
      r_sub    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_op_a  <= Op_A;
      r_op_b  <= Op_B;
      r_idx   <= '0;
`ifdef SUBTRACT_EN
      r_sub   <= Op_Sub;
      r_carry <= Op_Sub | Cin_In;
      if (Op_Sub) begin
        r_carry <= 1'b1;
      end else begin
        r_carry <= Cin_In;
      end
`else
      r_carry <= Cin_In;
`endif
    end else if (r_state == S_ADD) begin
      // Adder_Sum is only trusted here, where the adder is enabled.
      r_result[w_bit_base +: 8] <= Adder_Sum;
      r_carry                   <= Adder_Cout8;
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= Adder_Cout8;
        r_ovf  <= (w_a_msb == w_b_msb) && (Adder_Sum[7] != w_a_msb);
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign Result   = r_result;
  assign Cout_Out = r_cout;
  assign Overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multibyte_add_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multibyte_add_sequencer                                    |
// | Purpose  : Scoreboard bench for multibyte_add_sequencer. A behavioural   |
// |            8-bit adder answers the DUT; expected wide results come from  |
// |            plain arithmetic on the whole operands. Define SUBTRACT_EN    |
// |            to exercise the subtract option.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_multibyte_add_sequencer;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          In_Valid;
  logic          In_Ready;
  logic [W-1:0]  Op_A;
  logic [W-1:0]  Op_B;
  logic          Cin_In;
`ifdef SUBTRACT_EN
  logic          Op_Sub;
`endif
  logic [7:0]    Adder_A;
  logic [7:0]    Adder_B;
  logic          Adder_Cin0;
  logic          Adder_Enable;
  logic [7:0]    Adder_Sum;
  logic          Adder_Cout8;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [W-1:0]  Result;
  logic          Cout_Out;
  logic          Overflow;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_pop = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low

  multibyte_add_sequencer #(.NBYTES(NBYTES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .In_Valid     (In_Valid),
    .In_Ready     (In_Ready),
    .Op_A         (Op_A),
    .Op_B         (Op_B),
    .Cin_In       (Cin_In),
`ifdef SUBTRACT_EN
    .Op_Sub       (Op_Sub),
`endif
    .Adder_A      (Adder_A),
    .Adder_B      (Adder_B),
    .Adder_Cin0   (Adder_Cin0),
    .Adder_Enable (Adder_Enable),
    .Adder_Sum    (Adder_Sum),
    .Adder_Cout8  (Adder_Cout8),
    .Out_Valid    (Out_Valid),
    .Out_Ready    (Out_Ready),
    .Result       (Result),
    .Cout_Out     (Cout_Out),
    .Overflow     (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External adder: garbage while disabled so a stray sample is visible.
  always_comb begin
    if (Adder_Enable) {Adder_Cout8, Adder_Sum} = 9'h1A5;
    else {Adder_Cout8, Adder_Sum} = {1'b0, Adder_A} + {1'b0, Adder_B} + {8'h00, Adder_Cin0};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: whole-word arithmetic, no byte sequencing.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] bb;
    logic         c;
    bb    = sub ? ~b : b;
    c     = sub ? 1'b1 : cin;
    s     = {1'b0, a} + {1'b0, bb} + (W+1)'(c);
    e.res  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    e.acc  = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i += 32) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, output int acc);
    exp_t e;
    int   t;
    @(negedge clk);
    In_Valid = 1'b1;
    Op_A     = a;
    Op_B     = b;
    Cin_In   = cin;
`ifdef SUBTRACT_EN
    Op_Sub   = sub;
`endif
    t = 0;
    while (!In_Ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!In_Ready) begin
      fail_now("accept_timeout");
      In_Valid = 1'b0;
      acc = -1;
      return;
    end
    e     = model(a, b, cin, sub);
    e.acc = cyc + 1;
    sb.push_back(e);
    acc = e.acc;
    @(posedge clk);
    #1;
    In_Valid = 1'b0;
    Op_A     = rand_w();
    Op_B     = rand_w();
    Cin_In   = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic check_reset_values();
    chk("rst_result", Result, 0);
    chk("rst_cout", Cout_Out, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_adder_a", Adder_A, 0);
    chk("rst_adder_b", Adder_B, 0);
    chk("rst_adder_cin", Adder_Cin0, 0);
    chk("rst_adder_en", Adder_Enable, 1);
    chk("rst_in_ready", In_Ready, 1);
  endtask

  // Downstream ready, changed away from both clock edges
  initial begin
    Out_Ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       Out_Ready = 1'b1;
        1:       Out_Ready = 1'($urandom_range(0, 1));
        default: Out_Ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented result against the scoreboard head
  int  en_cnt = 0;
  bit  prev_valid = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      en_cnt     = 0;
      prev_valid = 0;
    end else begin
      if (!Adder_Enable) en_cnt++;
      else if (en_cnt != 0) begin
        chk("enable_low_cycles", en_cnt, NBYTES);
        en_cnt = 0;
      end
      if (Out_Valid) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          e = sb[0];
          if (!prev_valid) chk("latency", cyc - e.acc, NBYTES);
          chk("result", Result, e.res);
          chk("cout", Cout_Out, e.cout);
          chk("overflow", Overflow, e.ovf);
          chk("in_ready_busy", In_Ready, 0);
          if (Out_Ready) begin
            void'(sb.pop_front());
            last_pop = cyc + 1;
          end
        end
      end
      prev_valid = Out_Valid && !Out_Ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int acc2;
    int t;
    rst_n    = 1'b0;
    In_Valid = 1'b0;
    Op_A     = '0;
    Op_B     = '0;
    Cin_In   = 1'b0;
`ifdef SUBTRACT_EN
    Op_Sub   = 1'b0;
`endif
    // In_Valid asserted during reset must not be captured
    repeat (2) @(negedge clk);
    In_Valid = 1'b1;
    Op_A     = 32'hDEADBEEF;
    @(negedge clk);
    check_reset_values();
    In_Valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset_out_valid", Out_Valid, 0);
    chk("idle_after_reset_enable", Adder_Enable, 1);

    // Directed vectors
    ready_mode = 0;
    send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, acc);
    drain();
    chk("dir_ff_plus_1", Result, 32'h00000100);
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, acc);
    drain();
    chk("dir_wrap_result", Result, 32'h00000000);
    chk("dir_wrap_cout", Cout_Out, 1);
    send(32'h00000000, 32'h00000000, 1'b1, 1'b0, acc);
    drain();
    chk("dir_cin_only", Result, 32'h00000001);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, acc);
    drain();
    chk("dir_ovf_result", Result, 32'h80000000);
    chk("dir_ovf_flag", Overflow, 1);
    chk("dir_ovf_cout", Cout_Out, 0);

    // Back-pressure in DONE, then immediate re-issue
    ready_mode = 2;
    send(32'h01020304, 32'h10203040, 1'b0, 1'b0, acc);
    t = 0;
    while (!Out_Valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!Out_Valid) fail_now("done_timeout");
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", Out_Valid, 1);
      chk("hold_in_ready", In_Ready, 0);
      chk("hold_result", Result, 32'h11223344);
    end
    ready_mode = 0;
    send(32'h00000010, 32'h00000020, 1'b0, 1'b0, acc2);
    chk("reaccept_gap", acc2 - last_pop, 1);
    drain();

    // Reset in the middle of ADD
    send(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, acc);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_reset_values();
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (NBYTES + 3) @(negedge clk);
    chk("no_valid_after_abort", Out_Valid, 0);
    send(32'h12345678, 32'h11111111, 1'b0, 1'b0, acc);
    drain();
    chk("post_reset_result", Result, 32'h23456789);

`ifdef SUBTRACT_EN
    send(32'h00000005, 32'h00000007, 1'b1, 1'b1, acc);
    drain();
    chk("sub_result", Result, 32'hFFFFFFFE);
    chk("sub_cout", Cout_Out, 0);
    chk("sub_ovf", Overflow, 0);
`endif

    // Randomised traffic with random back-pressure and idle gaps
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      a = rand_w();
      b = rand_w();
      case ($urandom_range(0, 5))
        0: a = '1;
        1: b = {1'b0, {(W-1){1'b1}}};
        2: begin a = {1'b1, {(W-1){1'b0}}}; b = a; end
        default: ;
      endcase
      sub = 1'b0;
`ifdef SUBTRACT_EN
      sub = 1'($urandom);
`endif
      send(a, b, 1'($urandom), sub, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    ready_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
